// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: fetches one instruction word over a req/ack memory handshake and holds it for decode.
// Optional build macro IFU_PERF_CNT_EN adds saturating fetch/redirect performance counters.
module instruction_fetch_unit #(
    parameter int                    INSTR_WIDTH = 60,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    OPCODE_LSB  = 56
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   branch_en,
    input  logic                   jump_en,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  target_addr,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [3:0]             opcode,
    output logic [ADDR_WIDTH-1:0]  pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]            fetch_count,
    output logic [31:0]            redirect_count,
`endif
    output logic                   state_dbg
);

    typedef enum logic {
        ST_REQ   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     req_q, req_d;
    logic                     accept;
    logic                     redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

    // Handshake: a word is accepted only on an edge where imem_req=1 and imem_ack=1 in REQ;
    // imem_addr stays equal to pc while imem_req is high, and any other ack is ignored.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        req_d    = req_q;
        accept   = 1'b0;
        redirect = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    accept  = 1'b1;
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    state_d = ST_REQ;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    // Jump has priority; branch_taken only matters with branch_en.
                    if (jump_en || (branch_en && branch_taken)) begin
                        redirect = 1'b1;
                        pc_d     = target_addr;
                    end else begin
                        pc_d = pc_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign opcode      = valid_q ? instr_q[OPCODE_LSB +: 4] : 4'd0;
    assign state_dbg   = (state_q == ST_ISSUE);

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redirect_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (accept && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (redirect && (redirect_cnt_q != 32'hFFFF_FFFF)) begin
                redirect_cnt_q <= redirect_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redirect_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = accept ^ redirect;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential flow, memory wait, redirects, stall, wrap and reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [59:0] imem_rdata;
    logic        stall;
    logic        branch_en;
    logic        jump_en;
    logic        branch_taken;
    logic [15:0] target_addr;
    logic        instr_valid;
    logic [59:0] instr;
    logic [3:0]  opcode;
    logic [15:0] pc;
    logic        state_dbg;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    int checks;
    int failures;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_en(branch_en), .jump_en(jump_en),
        .branch_taken(branch_taken), .target_addr(target_addr),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .pc(pc),
`ifdef IFU_PERF_CNT_EN
        .fetch_count(fetch_count), .redirect_count(redirect_count),
`endif
        .state_dbg(state_dbg)
    );

    // ---- clock ----
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: opcode field is addr[3:0]+3, low bits carry the address.
    function automatic logic [59:0] mem_word(input logic [15:0] a);
        return {a[3:0] + 4'd3, 40'hC0FFEE1234, a};
    endfunction

    // ---- driver tasks ----
    task automatic step();
        @(negedge clk);
    endtask

    task automatic ack_word(input logic [59:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
    endtask

    task automatic exit_issue(input logic j, input logic b, input logic t, input logic [15:0] tgt);
        jump_en      = j;
        branch_en    = b;
        branch_taken = t;
        target_addr  = tgt;
        step();
        jump_en      = 1'b0;
        branch_en    = 1'b0;
        branch_taken = 1'b0;
        target_addr  = 16'h0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        branch_en = 1'b0; jump_en = 1'b0; branch_taken = 1'b0; target_addr = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 60'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (opcode !== 4'h0) begin failures++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        checks++; if (pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
        checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", state_dbg); end
`ifdef IFU_PERF_CNT_EN
        checks++; if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
            failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", fetch_count, redirect_count); end
`endif
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0);
        step();
        // Release with ack already high: the first edge only raises imem_req.
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got=%b exp=1", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL early_ack_ignored got=%b exp=0", instr_valid); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
                failures++; $display("FAIL seq_req[%0d] got=%b/%h exp=1/%h", k, imem_req, imem_addr, 16'(k)); end
            checks++; if (instr_valid !== 1'b0 || opcode !== 4'h0) begin
                failures++; $display("FAIL seq_idle[%0d] got=%b/%h exp=0/0", k, instr_valid, opcode); end
            ack_word(mem_word(16'(k)));
            checks++; if (instr_valid !== 1'b1 || instr !== mem_word(16'(k))) begin
                failures++; $display("FAIL seq_instr[%0d] got=%b/%h exp=1/%h", k, instr_valid, instr, mem_word(16'(k))); end
            checks++; if (opcode !== 4'(k + 3)) begin
                failures++; $display("FAIL seq_opcode[%0d] got=%h exp=%h", k, opcode, 4'(k + 3)); end
            checks++; if (imem_req !== 1'b0 || pc !== 16'(k) || state_dbg !== 1'b1) begin
                failures++; $display("FAIL seq_issue[%0d] got=%b/%h/%b exp=0/%h/1", k, imem_req, pc, state_dbg, 16'(k)); end
            step();
        end
    endtask

    task automatic test_mem_wait();
        ack_word(mem_word(16'h4));
        step();
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h5 || instr_valid !== 1'b0) begin
                failures++; $display("FAIL wait[%0d] got=%b/%h/%b exp=1/0005/0", i, imem_req, imem_addr, instr_valid); end
            if (i < 3) step();
        end
        ack_word(mem_word(16'h5));
        checks++; if (instr_valid !== 1'b1 || opcode !== 4'h8) begin
            failures++; $display("FAIL wait_issue got=%b/%h exp=1/8", instr_valid, opcode); end
    endtask

    task automatic test_redirect();
        exit_issue(1'b1, 1'b0, 1'b0, 16'h0010);
        checks++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) begin
            failures++; $display("FAIL jump_to_10 got=%h exp=0010", imem_addr); end
        ack_word(mem_word(16'h0010));
        exit_issue(1'b0, 1'b1, 1'b0, 16'h0200);
        checks++; if (imem_addr !== 16'h0011) begin
            failures++; $display("FAIL branch_not_taken got=%h exp=0011", imem_addr); end
        ack_word(mem_word(16'h0011));
        exit_issue(1'b1, 1'b0, 1'b0, 16'h0010);
        ack_word(mem_word(16'h0010));
        exit_issue(1'b1, 1'b0, 1'b0, 16'h0100);
        checks++; if (imem_addr !== 16'h0100) begin
            failures++; $display("FAIL jump_to_100 got=%h exp=0100", imem_addr); end
        ack_word(mem_word(16'h0100));
        exit_issue(1'b1, 1'b1, 1'b0, 16'h0ABC);
        checks++; if (imem_addr !== 16'h0ABC) begin
            failures++; $display("FAIL jump_over_branch got=%h exp=0abc", imem_addr); end
        ack_word(mem_word(16'h0ABC));
        exit_issue(1'b0, 1'b1, 1'b1, 16'h0FFF);
        checks++; if (imem_addr !== 16'h0FFF) begin
            failures++; $display("FAIL branch_taken got=%h exp=0fff", imem_addr); end
        ack_word(mem_word(16'h0FFF));
        exit_issue(1'b0, 1'b0, 1'b1, 16'h3333);
        checks++; if (imem_addr !== 16'h1000) begin
            failures++; $display("FAIL taken_without_branch got=%h exp=1000", imem_addr); end
    endtask

    task automatic test_stall();
        // Redirect inputs seen during REQ must not move the PC.
        jump_en = 1'b1; target_addr = 16'h5555;
        step();
        jump_en = 1'b0; target_addr = 16'h0;
        checks++; if (imem_addr !== 16'h1000 || imem_req !== 1'b1) begin
            failures++; $display("FAIL req_ignores_jump got=%h exp=1000", imem_addr); end
        ack_word(60'h500000000000000);
        stall = 1'b1;
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0099);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (instr !== 60'h500000000000000 || opcode !== 4'h5 || instr_valid !== 1'b1) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h/%h exp=500000000000000/5", i, instr, opcode); end
            checks++; if (pc !== 16'h1000 || imem_req !== 1'b0) begin
                failures++; $display("FAIL stall_pc[%0d] got=%h/%b exp=1000/0", i, pc, imem_req); end
        end
        stall = 1'b0; imem_ack = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h1001 || instr_valid !== 1'b0 || opcode !== 4'h0) begin
            failures++; $display("FAIL stall_resume got=%b/%h/%b/%h exp=1/1001/0/0", imem_req, imem_addr, instr_valid, opcode); end
    endtask

    task automatic test_wrap();
        ack_word(mem_word(16'h1001));
        exit_issue(1'b1, 1'b0, 1'b0, 16'hFFFF);
        checks++; if (imem_addr !== 16'hFFFF) begin
            failures++; $display("FAIL jump_to_ffff got=%h exp=ffff", imem_addr); end
        ack_word(mem_word(16'hFFFF));
        checks++; if (opcode !== 4'h2) begin
            failures++; $display("FAIL wrap_opcode got=%h exp=2", opcode); end
        step();
        checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
            failures++; $display("FAIL pc_wrap got=%h/%b exp=0000/1", imem_addr, imem_req); end
    endtask

    task automatic test_reset_mid();
        ack_word(mem_word(16'h0));
        exit_issue(1'b1, 1'b0, 1'b0, 16'h0042);
        checks++; if (imem_addr !== 16'h0042 || imem_req !== 1'b1) begin
            failures++; $display("FAIL pre_reset got=%h exp=0042", imem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 16'h0) begin
            failures++; $display("FAIL reset_mid_req got=%b/%b/%h exp=0/0/0000", imem_req, instr_valid, pc); end
        imem_ack = 1'b1; imem_rdata = mem_word(16'h0042);
        step();
        rst_n = 1'b1; imem_ack = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL restart_req got=%b/%h/%b exp=1/0000/0", imem_req, imem_addr, instr_valid); end
        ack_word(mem_word(16'h0));
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0 || opcode !== 4'h0 || instr !== 60'h0) begin
            failures++; $display("FAIL reset_mid_issue got=%b/%h/%h exp=0/0/0", instr_valid, opcode, instr); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            failures++; $display("FAIL restart_issue got=%b/%h exp=1/0000", imem_req, imem_addr); end
    endtask

`ifdef IFU_PERF_CNT_EN
    task automatic test_perf_counters();
        logic [15:0] a;
        checks++; if (fetch_count !== 32'd0 || redirect_count !== 32'd0) begin
            failures++; $display("FAIL perf_start got=%0d/%0d exp=0/0", fetch_count, redirect_count); end
        a = 16'h0;
        for (int i = 0; i < 10; i++) begin
            ack_word(mem_word(a));
            case (i)
                2: begin exit_issue(1'b1, 1'b0, 1'b0, 16'h0020); a = 16'h0020; end
                5: begin exit_issue(1'b0, 1'b1, 1'b1, 16'h0040); a = 16'h0040; end
                6: begin exit_issue(1'b0, 1'b1, 1'b0, 16'h0777); a = a + 16'h1; end
                8: begin exit_issue(1'b1, 1'b0, 1'b0, 16'h0060); a = 16'h0060; end
                default: begin exit_issue(1'b0, 1'b0, 1'b0, 16'h0); a = a + 16'h1; end
            endcase
        end
        checks++; if (fetch_count !== 32'd10) begin
            failures++; $display("FAIL fetch_count got=%0d exp=10", fetch_count); end
        checks++; if (redirect_count !== 32'd3) begin
            failures++; $display("FAIL redirect_count got=%0d exp=3", redirect_count); end
        checks++; if (imem_addr !== 16'h0061) begin
            failures++; $display("FAIL perf_final_addr got=%h exp=0061", imem_addr); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_mem_wait();
        test_redirect();
        test_stall();
        test_wrap();
        test_reset_mid();
`ifdef IFU_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Stage directly upstream of the control unit in the 60-bit processor.
- Fetches one 60-bit instruction at a time from instruction memory over a req/ack handshake and holds it for decode.
- Presents the 4-bit opcode to the control unit.
- Consumes the control unit's branch_en/jump_en, plus the ALU compare result, to select the next PC.

Parameters:
- INSTR_WIDTH, 60: instruction word width.
- ADDR_WIDTH, 16: PC / instruction address width.
- RESET_PC, 0: PC value loaded on reset.
- OPCODE_LSB, 56: LSB of the 4-bit opcode field; the field is instr[OPCODE_LSB+3:OPCODE_LSB].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_WIDTH  fetch address; equals pc.
- imem_ack  in  1  memory response valid; imem_rdata is sampled when imem_req=1 and imem_ack=1.
- imem_rdata  in  INSTR_WIDTH  fetched instruction word.
- stall  in  1  downstream hold; freezes the issued instruction.
- branch_en  in  1  from control unit; conditional branch decoded.
- jump_en  in  1  from control unit; unconditional jump decoded.
- branch_taken  in  1  ALU compare result for the current instruction.
- target_addr  in  ADDR_WIDTH  branch/jump destination.
- instr_valid  out  1  instr/opcode hold a valid instruction.
- instr  out  INSTR_WIDTH  registered instruction word.
- opcode  out  4  instr opcode field; forced to 0 when instr_valid=0.
- pc  out  ADDR_WIDTH  address of the current fetch/issued instruction.

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, pc=RESET_PC.
  - imem_req=0, instr=0, instr_valid=0, opcode=0.
  - Outputs go to reset values immediately, not at the next edge.
  - An outstanding request is abandoned; an ack arriving during reset is ignored.
- imem_req is registered. It rises on the first clock edge after rst_n deasserts.
- FSM has two states, REQ and ISSUE.
- REQ:
  - imem_req=1; imem_addr=pc, stable for as long as imem_req=1.
  - On an edge with imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go to ISSUE.
  - Without an ack, wait indefinitely. There is no timeout.
- ISSUE:
  - instr_valid=1; opcode drives the control unit combinationally from instr.
  - While stall=1: hold instr, pc and state.
  - On an edge with stall=0, load the next pc and go to REQ:
    - jump_en=1 → next pc = target_addr.
    - else branch_en=1 and branch_taken=1 → next pc = target_addr.
    - else → next pc = pc+1, modulo 2^ADDR_WIDTH.
  - On that same edge: instr_valid<=0, imem_req<=1.
- Priority: jump_en over branch_en when both are asserted.
- branch_taken is ignored unless branch_en=1. branch_en, jump_en, branch_taken and target_addr are sampled only on the ISSUE-exit edge.
- Wrap: pc=2^ADDR_WIDTH-1 with sequential flow → next pc is 0. No error flag.
- imem_ack while imem_req=0, or in ISSUE, is ignored.
- opcode = instr_valid ? instr[OPCODE_LSB+3:OPCODE_LSB] : 0. Opcode 0 decodes to all control enables low.
- Throughput: 2 cycles per instruction minimum (ack in the first REQ cycle, stall=0). Each memory wait cycle or stall cycle adds 1.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_count[31:0] and redirect_count[31:0], both reset to 0 asynchronously.
  - fetch_count increments on every accepted ack.
  - redirect_count increments on each ISSUE exit that loads target_addr.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: neither the ports nor the counter logic exist. All other behaviour is identical.

Test Plan:
- Reset then sequential flow: RESET_PC=0, ack immediate, no branches, stall=0 → imem_addr 0,1,2,3 on successive REQ cycles, instr_valid pulses every 2 cycles, opcode matches rdata[59:56].
- Memory wait: ack delayed 3 cycles at pc=5 → imem_req high for 4 cycles, imem_addr held at 5, instr_valid=0 throughout.
- Redirect:
  - jump_en=1, target_addr=0x0100 at pc=0x0010 → next imem_addr=0x0100.
  - branch_en=1, branch_taken=0 → next imem_addr=0x0011.
  - jump_en=1 and branch_en=1 together → target_addr is taken.
- Stall: stall=1 for 4 cycles in ISSUE with instr=0x5_00000000000000 → instr, opcode=5 and pc hold, imem_req=0; fetch resumes 1 cycle after stall falls.
- Wrap and reset: pc=0xFFFF, sequential flow → next imem_addr=0x0000. rst_n pulsed low mid-REQ → imem_req=0 and instr_valid=0 immediately, fetch restarts at RESET_PC.
- With IFU_PERF_CNT_EN: 10 fetches including 3 taken redirects → fetch_count=10, redirect_count=3.
